// File: rtl/led_frame_sched_pkg.sv
// Shared types and constants for the LED frame scheduler: FSM states, pixel width
// and the default latch gap.
package led_frame_sched_pkg;

    localparam int PIX_W            = 24;
    localparam int LATCH_CYCLES_DEF = 5000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED0 = 2'd1,
        ST_FEED1 = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    // One-hot string select for the feeding states, zero elsewhere.
    function automatic logic [1:0] feed_sel(input state_e st);
        logic [1:0] sel;
        case (st)
            ST_FEED0: sel = 2'b01;
            ST_FEED1: sel = 2'b10;
            default:  sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// Pixel path between the FWFT pixel FIFO, the scheduler and the two string serializers.
interface led_frame_sched_if;
    import led_frame_sched_pkg::*;

    logic [PIX_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [PIX_W-1:0] ch_data;
    logic [1:0]       ch_valid;
    logic [1:0]       ch_ready;

    modport master (
        input  fifo_dout, fifo_empty, ch_ready,
        output fifo_rd, ch_data, ch_valid
    );

    modport slave (
        output fifo_dout, fifo_empty, ch_ready,
        input  fifo_rd, ch_data, ch_valid
    );
endinterface

// File: rtl/led_frame_sched_latch_timer.sv
// Down-counter that times the string latch gap; done is high once CYCLES clocks have
// elapsed since load, counting the load cycle's successor as the first.
module led_latch_timer #(
    parameter int CYCLES = 5000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic done
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt_r;

    // Load with CYCLES-1 so that the owning state lasts exactly CYCLES clocks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= W'(CYCLES - 1);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == '0);
endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler: streams leds_per_string pixels to string 0, then string 1, then
// holds the latch gap before reporting the frame complete.
module led_frame_sched
    import led_frame_sched_pkg::*;
#(
    parameter int CNT_W        = 10,
    parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                frame_start,
    input  logic [CNT_W-1:0]    leds_per_string,
    led_frame_sched_if.master   pix,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_count
);
    state_e             state_r;
    logic [CNT_W-1:0]   len_r;
    logic [CNT_W-1:0]   pix_cnt_r;
    logic               pending_r;
    logic               aborted_r;
    logic               frame_done_r;
    logic [15:0]        frame_count_r;

    logic               cnt_hit_s;
    logic [1:0]         valid_s;
    logic               accept_s;
    logic               enter_latch_s;
    logic               latch_done_s;

    assign cnt_hit_s = (pix_cnt_r == len_r);

    // Offer the FIFO head only to the active string, only while enabled and short of its count.
    always_comb begin
        valid_s       = 2'b00;
        enter_latch_s = 1'b0;
        if (reset_n && enable && !pix.fifo_empty && !cnt_hit_s) begin
            valid_s = feed_sel(state_r);
        end else begin
            valid_s = 2'b00;
        end
        case (state_r)
            ST_FEED0: enter_latch_s = !enable;
            ST_FEED1: enter_latch_s = !enable || cnt_hit_s;
            default:  enter_latch_s = 1'b0;
        endcase
    end

    assign accept_s     = |(valid_s & pix.ch_ready);
    assign pix.ch_valid = valid_s;
    assign pix.fifo_rd  = accept_s;
    assign pix.ch_data  = pix.fifo_dout;
    assign busy         = reset_n && (state_r != ST_IDLE);
    assign frame_done   = reset_n && frame_done_r;
    assign frame_count  = frame_count_r;

    led_latch_timer #(.CYCLES(LATCH_CYCLES)) u_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (enter_latch_s),
        .done    (latch_done_s)
    );

    // Frame sequencing, start queueing and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            len_r         <= '0;
            pix_cnt_r     <= '0;
            pending_r     <= 1'b0;
            aborted_r     <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            frame_done_r <= 1'b0;
            if (frame_start && ((state_r != ST_IDLE) || !enable)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (enable && (frame_start || pending_r)) begin
                        state_r   <= ST_FEED0;
                        len_r     <= leds_per_string;
                        pix_cnt_r <= '0;
                        pending_r <= 1'b0;
                        aborted_r <= 1'b0;
                    end
                end
                ST_FEED0, ST_FEED1: begin
                    if (!enable) begin
                        // Abort: skip the rest of the frame but keep the latch gap.
                        state_r   <= ST_LATCH;
                        aborted_r <= 1'b1;
                    end else if (cnt_hit_s) begin
                        state_r   <= (state_r == ST_FEED0) ? ST_FEED1 : ST_LATCH;
                        pix_cnt_r <= '0;
                    end else if (accept_s) begin
                        pix_cnt_r <= pix_cnt_r + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (latch_done_s) begin
                        state_r      <= ST_IDLE;
                        frame_done_r <= 1'b1;
                        if (!aborted_r) begin
                            frame_count_r <= frame_count_r + 16'd1;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_sched.sv
// Self-checking bench for led_frame_sched: vector table of frames, hand-written
// corner sequences and randomized frames against a transaction-level pixel model.
module tb_led_frame_sched;
    import led_frame_sched_pkg::*;

    localparam int L  = 12;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic [CW-1:0] leds = '0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;

    led_frame_sched_if pif();

    led_frame_sched #(.CNT_W(CW), .LATCH_CYCLES(L)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .frame_start     (frame_start),
        .leds_per_string (leds),
        .pix             (pif),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int preload;
        int period;
        int rmode;
        int exp0;
        int exp1;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] fq[$];
    int          n_pushed = 0, n_popped = 0;
    int          cyc = 0, cur_len = 0, frame_pops = 0, dones = 0;
    int          n_pop[2];
    int          last_pop_cyc = 0, done_cyc = 0, ready_mode = 0;
    logic        o_rd, o_done, o_busy;
    logic [1:0]  o_valid;

    function automatic logic [23:0] px(int n);
        return 24'(n * 65793 + 15450);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_px();
        fq.push_back(px(n_pushed));
        n_pushed++;
    endtask

    task automatic flush();
        fq.delete();
        n_popped = n_pushed;
        frame_pops = 0;
    endtask

    // One clock: drive, settle, observe and score at mid-cycle, then advance past the edge.
    task automatic tick();
        case (ready_mode)
            0:       pif.ch_ready = 2'b11;
            1:       pif.ch_ready = {1'b1, 1'(cyc % 2)};
            default: pif.ch_ready = 2'($urandom);
        endcase
        pif.fifo_empty = (fq.size() == 0);
        pif.fifo_dout  = (fq.size() == 0) ? 24'h0 : fq[0];
        #4;
        o_rd = pif.fifo_rd; o_valid = pif.ch_valid; o_busy = busy; o_done = frame_done;
        chk("valid_onehot", int'($countones(o_valid) <= 1), 1);
        chk("rd_vs_handshake", int'(o_rd), int'(|(o_valid & pif.ch_ready)));
        chk("data_passthru", int'(pif.ch_data), int'(pif.fifo_dout));
        if (pif.fifo_empty) chk("valid_when_empty", int'(o_valid), 0);
        if (o_rd) begin
            // The first cur_len pixels of a frame belong to string 0, the rest to string 1.
            chk("pop_channel", int'(o_valid[1]), int'(frame_pops >= cur_len));
            chk("pop_data", int'(pif.ch_data), int'(px(n_popped)));
            n_pop[o_valid[1]]++;
            frame_pops++;
            last_pop_cyc = cyc;
        end
        if (o_done) begin
            dones++;
            done_cyc = cyc;
            frame_pops = 0;
        end
        @(posedge clk);
        #1;
        if (o_rd && fq.size() != 0) begin
            void'(fq.pop_front());
            n_popped++;
        end
        cyc++;
    endtask

    task automatic run_frame(input int len, input int preload, input int period,
                             input int rmode, input int exp0, input int exp1);
        int start_cnt, pushed, s;
        start_cnt = int'(frame_count);
        ready_mode = rmode; leds = CW'(len); cur_len = len;
        n_pop[0] = 0; n_pop[1] = 0; dones = 0; frame_pops = 0;
        for (int i = 0; i < preload; i++) push_px();
        pushed = preload;
        frame_start = 1'b1; s = cyc; tick(); frame_start = 1'b0;
        for (int i = 0; i < 1500 && dones == 0; i++) begin
            if (period != 0 && pushed < 2 * len && (cyc % period) == 0) begin
                push_px();
                pushed++;
            end
            tick();
        end
        chk("frame_done_seen", dones, 1);
        chk("busy_at_done", int'(o_busy), 0);
        chk("pops_ch0", n_pop[0], exp0);
        chk("pops_ch1", n_pop[1], exp1);
        chk("frame_count", int'(frame_count), int'(16'(start_cnt + 1)));
        // Edges counted from the edge that sampled frame_start / made the last pop.
        if (len == 0) chk("len0_done_latency", done_cyc - s - 1, L + 2);
        else          chk("last_pop_to_done", done_cyc - last_pop_cyc - 1, L + 1);
        tick();
        chk("done_single_cycle", int'(o_done), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int start_cnt, s, e;
        tbl[0] = '{4, 8, 0, 0, 4, 4};
        tbl[1] = '{4, 0, 10, 0, 4, 4};
        tbl[2] = '{4, 8, 0, 1, 4, 4};
        tbl[3] = '{0, 0, 0, 0, 0, 0};
        tbl[4] = '{3, 2, 3, 2, 3, 3};
        tbl[5] = '{1, 2, 0, 2, 1, 1};
        n_pop[0] = 0; n_pop[1] = 0;

        tick(); tick();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_rd", int'(o_rd), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        reset_n = 1'b1; enable = 1'b1;
        tick();
        chk("post_rst_busy", int'(o_busy), 0);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].len, tbl[i].preload, tbl[i].period, tbl[i].rmode, tbl[i].exp0, tbl[i].exp1);

        // Two extra starts during a frame queue exactly one more frame.
        start_cnt = int'(frame_count); leds = CW'(2); cur_len = 2; ready_mode = 0; dones = 0;
        for (int i = 0; i < 8; i++) push_px();
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0; repeat (3) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 1000 && dones < 2; i++) tick();
        repeat (L + 10) tick();
        chk("dbl_start_dones", dones, 2);
        chk("dbl_start_count", int'(frame_count), int'(16'(start_cnt + 2)));
        chk("dbl_start_idle", int'(o_busy), 0);
        chk("dbl_start_drained", fq.size(), 0);

        // A start while disabled is held until enable returns.
        start_cnt = int'(frame_count); leds = '0; cur_len = 0; dones = 0;
        enable = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (3) tick();
        chk("pend_hold_idle", int'(o_busy), 0);
        enable = 1'b1; tick(); tick();
        chk("pend_started", int'(o_busy), 1);
        for (int i = 0; i < 200 && dones == 0; i++) tick();
        chk("pend_count", int'(frame_count), int'(16'(start_cnt + 1)));

        // Start coincident with the LATCH->IDLE edge becomes the next frame.
        start_cnt = int'(frame_count); dones = 0;
        frame_start = 1'b1; s = cyc; tick(); frame_start = 1'b0;
        while (cyc < s + L + 2) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("coincide_busy", int'(o_busy), 1);
        tick();
        chk("coincide_done", int'(o_done), 1);
        chk("coincide_idle", int'(o_busy), 0);
        tick();
        chk("coincide_next_busy", int'(o_busy), 1);
        for (int i = 0; i < 200 && dones < 2; i++) tick();
        chk("coincide_count", int'(frame_count), int'(16'(start_cnt + 2)));

        // Disable after two pops aborts to the latch gap without counting the frame.
        start_cnt = int'(frame_count); leds = CW'(4); cur_len = 4; dones = 0;
        n_pop[0] = 0; n_pop[1] = 0;
        for (int i = 0; i < 8; i++) push_px();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 100 && n_pop[0] < 2; i++) tick();
        enable = 1'b0; e = cyc; tick();
        chk("abort_no_pop", int'(o_rd), 0);
        for (int i = 0; i < 200 && dones == 0; i++) tick();
        chk("abort_done", dones, 1);
        chk("abort_pops0", n_pop[0], 2);
        chk("abort_pops1", n_pop[1], 0);
        chk("abort_count", int'(frame_count), start_cnt);
        chk("abort_latency", done_cyc - e, L + 1);
        enable = 1'b1; flush();

        for (int k = 0; k < 12; k++) begin
            int len, pre, per;
            len = int'($urandom_range(0, 5));
            pre = int'($urandom_range(0, 2 * len));
            per = int'($urandom_range(1, 4));
            run_frame(len, pre, per, 2, len, len);
        end

        // Reset while feeding string 1.
        leds = CW'(4); cur_len = 4; ready_mode = 0; n_pop[0] = 0; n_pop[1] = 0;
        for (int i = 0; i < 8; i++) push_px();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 100 && n_pop[1] < 1; i++) tick();
        reset_n = 1'b0; tick();
        chk("rst_mid_rd", int'(o_rd), 0);
        chk("rst_mid_valid", int'(o_valid), 0);
        chk("rst_mid_busy", int'(o_busy), 0);
        chk("rst_mid_done", int'(o_done), 0);
        reset_n = 1'b1; tick();
        chk("rst_mid_idle", int'(o_busy), 0);
        chk("rst_mid_no_valid", int'(o_valid), 0);
        chk("rst_mid_count", int'(frame_count), 0);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_frame_sched.md
LED_FRAME_SCHED -- requirements
Module: led_frame_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of the per-string LED count.
REQ-002 SHALL have parameter LATCH_CYCLES, default 5000, string latch/reset gap in clocks (50 us at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the block has exactly one clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  input  1  scheduler enable (GPMC control register bit).
REQ-006 SHALL have port frame_start  input  1  single-cycle pulse requesting one frame.
REQ-007 SHALL have port leds_per_string  input  CNT_W  pixels per string, sampled at frame start.
REQ-008 SHALL have port fifo_dout  input  24  pixel at the head of a first-word-fall-through pixel FIFO.
REQ-009 SHALL have port fifo_empty  input  1  pixel FIFO empty.
REQ-010 SHALL have port fifo_rd  output  1  pops the FIFO head.
REQ-011 SHALL have port ch_data  output  24  pixel to the serializers, shared by both channels.
REQ-012 SHALL have port ch_valid  output  2  per-string valid, one-hot or zero.
REQ-013 SHALL have port ch_ready  input  2  per-string serializer ready.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port frame_done  output  1  single-cycle pulse at frame completion.
REQ-016 SHALL have port frame_count  output  16  completed-frame counter, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, FEED0, FEED1, LATCH.
REQ-018 SHALL transition IDLE->FEED0 when enable=1 and either frame_start=1 or start_pending=1, and SHALL register leds_per_string into len_q and clear pix_cnt on that transition.
REQ-019 SHALL drive ch_valid[k]=!fifo_empty in FEEDk, and ch_valid[k]=0 otherwise.
REQ-020 SHALL drive ch_data=fifo_dout at all times.
REQ-021 SHALL drive fifo_rd=ch_valid[k]&ch_ready[k] combinationally (zero latency), with exactly one pop per accepted pixel.
REQ-022 SHALL increment pix_cnt on each accepted pixel.
REQ-023 SHALL move FEED0->FEED1 in the cycle after pix_cnt reaches len_q, clearing pix_cnt, and SHALL move FEED1->LATCH in the same way.
REQ-024 SHALL wait indefinitely in FEEDk while fifo_empty=1, with no pop and no timeout.
REQ-025 SHALL, when len_q=0, pass through FEED0 and FEED1 for one cycle each with no pops.
REQ-026 SHALL, in LATCH, count LATCH_CYCLES clocks, then return to IDLE, pulse frame_done for 1 cycle, and increment frame_count.
REQ-027 SHALL set start_pending when frame_start arrives while busy=1 or while enable=0 (at most one pending frame is held), and SHALL clear start_pending on the IDLE->FEED0 transition.
REQ-028 SHALL, on enable=0 during FEED0 or FEED1, abort to LATCH on the next clock with no further pops; an aborted frame still pulses frame_done but does not increment frame_count.
REQ-029 SHALL run the LATCH count to completion regardless of enable.
REQ-030 SHALL accept a frame_start coincident with the LATCH->IDLE transition as pending, so the next frame begins one cycle after IDLE.

Reset
REQ-031 SHALL, when reset_n=0 at a clk edge, force state IDLE and clear pix_cnt, the latch counter, start_pending and frame_count.
REQ-032 SHALL hold fifo_rd=0, ch_valid=0, busy=0 and frame_done=0 during reset.
REQ-033 SHALL honour reset mid-frame immediately, with no pop in the reset cycle and no LATCH gap.

Structure
REQ-034 SHALL place the state enumeration, the 24-bit pixel width constant and the default LATCH_CYCLES in the shared LED package.
REQ-035 SHALL be a single module; the latch-gap down-counter MAY be a sub-module named led_latch_timer.

Verification
REQ-036 SHALL cover: leds_per_string=4, 8 pixels preloaded, ch_ready=2'b11, frame_start -> 4 pops on ch_valid[0], then 4 on ch_valid[1], busy until LATCH_CYCLES after the last pop, frame_done=1 cycle, frame_count=1.
REQ-037 SHALL cover: FIFO starting empty, pixels trickled in 1 per 10 cycles -> no pop while empty, and all 8 pixels delivered in order.
REQ-038 SHALL cover: ch_ready[0] toggling 1/0 -> pops only on cycles where ready=1, with pixel order preserved.
REQ-039 SHALL cover: frame_start pulsed twice during frame 1 -> exactly one extra frame, with frame_count=2.
REQ-040 SHALL cover: enable dropped after 2 pops -> state LATCH, no further pops, frame_done pulse, frame_count unchanged.
REQ-041 SHALL cover: leds_per_string=0 -> zero pops, with frame_done after LATCH_CYCLES+2; and reset_n=0 mid-FEED1 -> IDLE on the next edge with all outputs 0.
